// File: rtl/bank_byte_framer.sv
// Frames an ASCII puzzle file into the solver digit stream (digit lookahead, commit gaps, final commit).
// One registered cycle per accepted byte; in_ready falls after the in_last byte and stays low through drain and done.
module bank_byte_framer #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [3:0]       data_out,
   output logic             wr_en,
   output logic             bank_end,
   output logic             done,
   output logic [CNT_W-1:0] bank_count,
   output logic [ERR_W-1:0] err_count
);
   typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_FLUSH, ST_DONE} state_t;

   state_t           r_state;
   logic [3:0]       r_pend;
   logic             r_fl_dig;
   logic             r_fl_gap;
   logic             r_rdy;
   logic             r_wr;
   logic             r_end;
   logic             r_done;
   logic [3:0]       r_dat;
   logic [CNT_W-1:0] r_banks;
   logic [ERR_W-1:0] r_errs;

   logic             w_acc;
   logic             w_is_dig;
   logic             w_is_nl;
   logic             w_is_cr;
   logic             w_is_bad;
   logic [3:0]       w_dig;

   assign w_acc    = in_valid && r_rdy;
   assign w_is_dig = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_is_nl  = (in_data == 8'h0A);
   assign w_is_cr  = (in_data == 8'h0D);
   assign w_is_bad = !(w_is_dig || w_is_nl || w_is_cr);
   assign w_dig    = in_data[3:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pend   <= '0;
         r_fl_dig <= 1'b0;
         r_fl_gap <= 1'b0;
         r_rdy    <= 1'b0;
         r_wr     <= 1'b0;
         r_end    <= 1'b0;
         r_done   <= 1'b0;
         r_dat    <= '0;
         r_banks  <= '0;
         r_errs   <= '0;
      end else begin
         // FILL unless an item overrides it below
         r_wr  <= 1'b1;
         r_dat <= '0;
         r_end <= 1'b0;
         case (r_state)
            ST_IDLE, ST_OPEN: begin
               r_rdy <= 1'b1;
               if (w_acc) begin
                  if (w_is_bad && (r_errs != '1))
                     r_errs <= r_errs + 1'b1;
                  if (w_is_dig) begin
                     r_pend <= w_dig;
                     if (r_state == ST_IDLE)
                        r_wr <= 1'b0;
                     else
                        r_dat <= r_pend;
                     r_state <= ST_OPEN;
                  end else if ((r_state == ST_OPEN) && (w_is_nl || in_last)) begin
                     r_dat   <= r_pend;
                     r_end   <= 1'b1;
                     r_banks <= r_banks + 1'b1;
                     r_state <= ST_IDLE;
                  end else if (in_last) begin
                     r_wr <= 1'b0;
                  end
                  // End of file: remember what is still owed, drained from FLUSH
                  if (in_last) begin
                     r_state  <= ST_FLUSH;
                     r_rdy    <= 1'b0;
                     r_fl_dig <= w_is_dig;
                     r_fl_gap <= w_is_dig || (r_state == ST_OPEN);
                  end
               end
            end
            ST_FLUSH: begin
               if (r_fl_dig) begin
                  r_dat    <= r_pend;
                  r_end    <= 1'b1;
                  r_banks  <= r_banks + 1'b1;
                  r_fl_dig <= 1'b0;
               end else if (r_fl_gap) begin
                  r_wr     <= 1'b0;
                  r_fl_gap <= 1'b0;
               end else begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_DONE;
            end
         endcase
      end
   end

   assign in_ready   = r_rdy;
   assign data_out   = r_dat;
   assign wr_en      = r_wr;
   assign bank_end   = r_end;
   assign done       = r_done;
   assign bank_count = r_banks;
   assign err_count  = r_errs;
endmodule

// File: tb/tb_bank_byte_framer.sv
// Scoreboard bench for bank_byte_framer: text-level reference model feeds an expected item queue,
// a monitor pops and compares, and a small solver folds the DUT stream into a joltage sum.
module tb_bank_byte_framer;
   localparam int CNT_W = 4;
   localparam int ERR_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_last = 1'b0;
   logic             in_ready;
   logic [3:0]       data_out;
   logic             wr_en;
   logic             bank_end;
   logic             done;
   logic [CNT_W-1:0] bank_count;
   logic [ERR_W-1:0] err_count;

   bank_byte_framer #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .data_out(data_out),
      .wr_en(wr_en), .bank_end(bank_end), .done(done),
      .bank_count(bank_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       gap;
      logic       last;
      logic [3:0] d;
   } item_t;

   item_t      exp_q[$];
   logic [7:0] file_q[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_banks, exp_errs, exp_sum;
   bit         sum_ok;

   bit draining, done_seen, prev_gap, sol_closed;
   int sol_sum, sol_best, sol_maxd;
   logic m_acc, m_last;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int pair_max(input int ds[$]);
      int best = 0;
      for (int i = 0; i < ds.size(); i++)
         for (int j = i + 1; j < ds.size(); j++)
            if (ds[i] * 10 + ds[j] > best) best = ds[i] * 10 + ds[j];
      return best;
   endfunction

   // Text-level model: split into lines, keep digits, each non-empty line is a bank
   task automatic build_model();
      int         line[$];
      item_t      it;
      bit         eol;
      logic [7:0] b;
      exp_banks = 0; exp_errs = 0; exp_sum = 0; sum_ok = 1;
      for (int i = 0; i <= file_q.size(); i++) begin
         eol = (i == file_q.size());
         if (!eol) begin
            b = file_q[i];
            eol = (b == 8'h0A);
            if (b >= 8'h30 && b <= 8'h39) line.push_back(int'(b) - 48);
            else if (b != 8'h0A && b != 8'h0D) exp_errs++;
         end
         if (eol && line.size() > 0) begin
            it = '{gap: 1'b1, last: 1'b0, d: 4'd0};
            exp_q.push_back(it);
            for (int k = 0; k < line.size(); k++) begin
               it = '{gap: 1'b0, last: (k == line.size() - 1), d: 4'(line[k])};
               // a zero digit that does not end its bank looks exactly like FILL
               if (it.d != 0 || it.last) exp_q.push_back(it);
            end
            exp_banks++;
            if (line.size() < 2) sum_ok = 0;
            exp_sum += pair_max(line);
            line.delete();
         end
      end
      it = '{gap: 1'b1, last: 1'b0, d: 4'd0};
      exp_q.push_back(it);
      exp_banks = exp_banks % (1 << CNT_W);
      if (exp_errs > (1 << ERR_W) - 1) exp_errs = (1 << ERR_W) - 1;
   endtask

   task automatic load(input string s);
      file_q.delete();
      for (int i = 0; i < s.len(); i++) file_q.push_back(s[i]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_data_out", data_out, 0);
      check("rst_bank_end", bank_end, 0);
      check("rst_done", done, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_bank_count", bank_count, 0);
      check("rst_err_count", err_count, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("first_cycle_fill_ready", {in_ready, wr_en, data_out, bank_end}, 7'b1100000);
   endtask

   // stop_after < 0 sends the whole file and waits for done
   task automatic send_file(input int vld_pct, input int stop_after);
      int guard;
      bit acc;
      build_model();
      for (int i = 0; i < file_q.size(); i++) begin
         if (i == stop_after) return;
         acc = 0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) < vld_pct);
            in_data  = in_valid ? file_q[i] : 8'($urandom);
            in_last  = in_valid ? (i == file_q.size() - 1) : 1'($urandom);
            acc = in_valid && in_ready;
            guard++;
            if (!acc && guard > 300) begin
               check("in_ready_stuck_low", in_ready, 1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      guard = 0;
      while (!done && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("done_reached", done, 1);
      check("queue_drained", exp_q.size(), 0);
      check("bank_count", bank_count, exp_banks);
      check("err_count", err_count, exp_errs);
      if (sum_ok) check("solver_sum", sol_sum, exp_sum);
   endtask

   task automatic mon_cycle(input logic acc, input logic last);
      bit    fill;
      item_t it;
      fill = wr_en && (data_out == 4'd0) && !bank_end;
      if (last) begin
         draining = 1;
         check("in_ready_drop_after_last", in_ready, 0);
      end
      if (done) begin
         if (!done_seen) begin
            done_seen = 1;
            check("done_follows_gap", prev_gap, 1);
            check("done_nothing_pending", exp_q.size(), 0);
         end
         check("done_fill_not_ready", {wr_en, data_out, bank_end, in_ready}, 7'b1000000);
      end else begin
         if (!acc && !draining)
            check("no_accept_fill", {wr_en, data_out, bank_end}, 6'b100000);
         if (!fill) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_item actual=wr%0d/d%0d/end%0d required=none",
                        wr_en, data_out, bank_end);
            end else begin
               it = exp_q.pop_front();
               check("item", {!wr_en, bank_end, data_out}, {it.gap, it.last, it.d});
            end
         end
      end
      if (!wr_en) begin
         sol_sum += sol_best;
         sol_best = 0; sol_maxd = -1; sol_closed = 0;
      end else if (!sol_closed) begin
         if (sol_maxd >= 0 && sol_maxd * 10 + int'(data_out) > sol_best)
            sol_best = sol_maxd * 10 + int'(data_out);
         if (int'(data_out) > sol_maxd) sol_maxd = int'(data_out);
         if (bank_end) sol_closed = 1;
      end
      prev_gap = !wr_en;
   endtask

   always begin
      @(posedge clk);
      m_acc  = rst_n && in_valid && in_ready;
      m_last = m_acc && in_last;
      #1;
      if (!rst_n) begin
         draining = 0; done_seen = 0; prev_gap = 0; sol_closed = 0;
         sol_sum = 0; sol_best = 0; sol_maxd = -1;
      end else begin
         mon_cycle(m_acc, m_last);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n, r;
      logic [7:0] b;

      do_reset(); load("912\n"); send_file(100, -1);
      do_reset();
      load("987654321111111\n811111111111119\n234234234234278\n818181911112111\n");
      send_file(100, -1);
      do_reset(); load("81"); send_file(100, -1);
      do_reset(); load("34\r\n\r\n56\n"); send_file(100, -1);
      do_reset(); load("5x7\n"); send_file(50, -1);

      do_reset(); load("98765"); send_file(100, 3);
      do_reset(); load("12\n"); send_file(100, -1);

      do_reset(); load("");
      for (int i = 0; i < 18; i++) begin
         file_q.push_back(8'h31); file_q.push_back(8'h31); file_q.push_back(8'h0A);
      end
      send_file(100, -1);

      do_reset(); load("xxxxxxxxxxxxxxxxxxxx55\n"); send_file(70, -1);

      for (int f = 0; f < 8; f++) begin
         file_q.delete();
         n = $urandom_range(40, 10);
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(99);
            if (r < 62) b = 8'h30 + 8'($urandom_range(9));
            else if (r < 80) b = 8'h0A;
            else if (r < 88) b = 8'h0D;
            else begin
               b = 8'h0A;
               while (b == 8'h0A || b == 8'h0D || (b >= 8'h30 && b <= 8'h39))
                  b = 8'($urandom_range(255));
            end
            file_q.push_back(b);
         end
         do_reset();
         send_file($urandom_range(100, 40), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
